// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;

  // A decode-stage source collides with the execute-stage destination.
  function automatic logic src_match(input logic use_src, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_src && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count enabled cycles, never wrapping past the maximum.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls with timeout, load-use bubbles,
// taken-branch flushes and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_l1,
  input  logic [4:0]       rs2_l1,
  input  logic             use_rs1_l1,
  input  logic             use_rs2_l1,
  input  logic [4:0]       rd_l2,
  input  logic             load_l2,
  input  logic             branch_taken_l2,
  input  logic             mem_req_l3,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             block_l1,
  output logic             block_l2,
  output logic             block_l3,
  output logic             clear_l1,
  output logic             clear_l2,
  output logic             clear_l3,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout
);

  // Wait counter spans 0..TIMEOUT_CYC-1; the last value is the limit cycle.
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  hz_state_e         state_r, state_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic              mem_stall_s;
  logic              load_use_s;

  assign mem_stall_s = mem_req_l3 && !mem_ack;
  assign load_use_s  = load_l2 && (rd_l2 != 5'd0) &&
                       (src_match(use_rs1_l1, rs1_l1, rd_l2) ||
                        src_match(use_rs2_l1, rs2_l1, rd_l2));

  // State and wait-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Next-state logic; an ack in the limit cycle returns to RUN, not ERR.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      RUN: begin
        if (mem_stall_s) begin
          state_s    = MEM_WAIT;
          wait_cnt_s = '0;
        end else begin
          state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall_s) begin
          state_s    = RUN;
          wait_cnt_s = '0;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s = ERR;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ERR: begin
        state_s = ERR;
      end
      default: begin
        state_s    = RUN;
        wait_cnt_s = '0;
      end
    endcase
  end

  // Output decode: reset flush, error freeze, then stall > branch > load-use.
  always_comb begin
    pc_hold  = 1'b0;
    block_l1 = 1'b0;
    block_l2 = 1'b0;
    block_l3 = 1'b0;
    clear_l1 = 1'b0;
    clear_l2 = 1'b0;
    clear_l3 = 1'b0;
    if (rst) begin
      clear_l1 = 1'b1;
      clear_l2 = 1'b1;
      clear_l3 = 1'b1;
    end else begin
      case (state_r)
        ERR: begin
          pc_hold  = 1'b1;
          block_l1 = 1'b1;
          block_l2 = 1'b1;
          block_l3 = 1'b1;
        end
        RUN, MEM_WAIT: begin
          if (mem_stall_s) begin
            pc_hold  = 1'b1;
            block_l1 = 1'b1;
            block_l2 = 1'b1;
            block_l3 = 1'b1;
          end else if (branch_taken_l2) begin
            clear_l1 = 1'b1;
            clear_l2 = 1'b1;
          end else if (load_use_s) begin
            pc_hold  = 1'b1;
            block_l1 = 1'b1;
            clear_l2 = 1'b1;
          end else begin
            pc_hold = 1'b0;
          end
        end
        default: begin
          pc_hold = 1'b0;
        end
      endcase
    end
  end

  assign mem_timeout = (state_r == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (pc_hold),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one default instance and one with a short
// timeout and narrow counter, both fed the same stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_l1 = 5'd0, rs2_l1 = 5'd0, rd_l2 = 5'd0;
  logic       use_rs1_l1 = 1'b0, use_rs2_l1 = 1'b0, load_l2 = 1'b0;
  logic       branch_taken_l2 = 1'b0, mem_req_l3 = 1'b0, mem_ack = 1'b0;

  logic        hold_a, b1_a, b2_a, b3_a, c1_a, c2_a, c3_a, tmo_a;
  logic        hold_b, b1_b, b2_b, b3_b, c1_b, c2_b, c3_b, tmo_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .rs1_l1(rs1_l1), .rs2_l1(rs2_l1),
    .use_rs1_l1(use_rs1_l1), .use_rs2_l1(use_rs2_l1), .rd_l2(rd_l2),
    .load_l2(load_l2), .branch_taken_l2(branch_taken_l2),
    .mem_req_l3(mem_req_l3), .mem_ack(mem_ack), .pc_hold(hold_a),
    .block_l1(b1_a), .block_l2(b2_a), .block_l3(b3_a),
    .clear_l1(c1_a), .clear_l2(c2_a), .clear_l3(c3_a),
    .stall_cnt(cnt_a), .mem_timeout(tmo_a));

  hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rs1_l1(rs1_l1), .rs2_l1(rs2_l1),
    .use_rs1_l1(use_rs1_l1), .use_rs2_l1(use_rs2_l1), .rd_l2(rd_l2),
    .load_l2(load_l2), .branch_taken_l2(branch_taken_l2),
    .mem_req_l3(mem_req_l3), .mem_ack(mem_ack), .pc_hold(hold_b),
    .block_l1(b1_b), .block_l2(b2_b), .block_l3(b3_b),
    .clear_l1(c1_b), .clear_l2(c2_b), .clear_l3(c3_b),
    .stall_cnt(cnt_b), .mem_timeout(tmo_b));

  // ctl = {pc_hold, block_l3, block_l2, block_l1, clear_l3, clear_l2, clear_l1, mem_timeout}
  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] cnt;
    bit          chk_state;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state per instance: 0 = default, 1 = short timeout.
  bit known[2]   = '{1'b0, 1'b0};
  bit in_err[2]  = '{1'b0, 1'b0};
  bit in_wait[2] = '{1'b0, 1'b0};
  int waited[2]  = '{0, 0};
  int stalls[2]  = '{0, 0};
  int tmo_lim[2] = '{255, 4};
  int cnt_max[2] = '{65535, 15};

  function automatic exp_t model(int k, bit r);
    exp_t e;
    bit hold, b1, b2, b3, c1, c2, c3, ms, lu;
    {hold, b1, b2, b3, c1, c2, c3} = 7'd0;
    ms = mem_req_l3 && !mem_ack;
    lu = load_l2 && (rd_l2 != 5'd0) &&
         ((use_rs1_l1 && rs1_l1 == rd_l2) || (use_rs2_l1 && rs2_l1 == rd_l2));
    if (r) begin
      {c1, c2, c3} = 3'b111;
    end else if (in_err[k]) begin
      {hold, b1, b2, b3} = 4'b1111;
    end else if (ms) begin
      {hold, b1, b2, b3} = 4'b1111;
    end else if (branch_taken_l2) begin
      {c1, c2} = 2'b11;
    end else if (lu) begin
      {hold, b1, c2} = 3'b111;
    end
    e.ctl       = {hold, b3, b2, b1, c3, c2, c1, known[k] && in_err[k]};
    e.cnt       = 16'(stalls[k]);
    e.chk_state = known[k];
    e.cyc       = cyc;
    if (r) begin
      known[k] = 1'b1; in_err[k] = 1'b0; in_wait[k] = 1'b0;
      waited[k] = 0; stalls[k] = 0;
    end else begin
      if (hold && stalls[k] < cnt_max[k]) stalls[k]++;
      if (in_err[k]) begin
        in_err[k] = 1'b1;
      end else if (in_wait[k]) begin
        if (!ms) in_wait[k] = 1'b0;
        else if (waited[k] + 1 >= tmo_lim[k]) begin in_err[k] = 1'b1; in_wait[k] = 1'b0; end
        else waited[k]++;
      end else if (ms) begin
        in_wait[k] = 1'b1; waited[k] = 0;
      end
    end
    return e;
  endfunction

  task automatic step(input bit r, input logic [4:0] s1, input logic [4:0] s2,
                      input bit u1, input bit u2, input logic [4:0] d, input bit ld,
                      input bit br, input bit mr, input bit ma);
    @(posedge clk);
    #1;
    cyc++;
    rst = r; rs1_l1 = s1; rs2_l1 = s2; use_rs1_l1 = u1; use_rs2_l1 = u2;
    rd_l2 = d; load_l2 = ld; branch_taken_l2 = br; mem_req_l3 = mr; mem_ack = ma;
    q_a.push_back(model(0, r));
    q_b.push_back(model(1, r));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string nm, input exp_t e, input logic [7:0] ctl,
                       input logic [15:0] cnt);
    tests++;
    if (e.chk_state ? (ctl !== e.ctl) : (ctl[7:1] !== e.ctl[7:1])) begin
      fails++;
      $display("FAIL %s ctl cyc=%0d got=%b exp=%b", nm, e.cyc, ctl, e.ctl);
    end
    if (e.chk_state) begin
      tests++;
      if (cnt !== e.cnt) begin
        fails++;
        $display("FAIL %s stall_cnt cyc=%0d got=%0d exp=%0d", nm, e.cyc, cnt, e.cnt);
      end
    end
  endtask

  // Monitor: compare every presented output cycle against the queued expectation.
  always @(negedge clk) begin
    if (q_a.size() > 0)
      check("dut_a", q_a.pop_front(), {hold_a, b3_a, b2_a, b1_a, c3_a, c2_a, c1_a, tmo_a}, cnt_a);
    if (q_b.size() > 0)
      check("dut_b", q_b.pop_front(), {hold_b, b3_b, b2_b, b1_b, c3_b, c2_b, c1_b, tmo_b},
            {12'd0, cnt_b});
  end

  initial begin
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // load-use on r5, then the same pattern on r0 (no stall)
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // branch wins over load-use
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    // three-cycle memory stall then ack
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // held request with no ack: both instances eventually time out
    for (int i = 0; i < 262; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    // ack exactly in the limit cycle of the short-timeout instance
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    // twenty load-use stalls saturate the narrow counter
    for (int i = 0; i < 20; i++) step(1'b0, 5'd9, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 39) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 1'($urandom));
    end
    idle(1);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", q_a.size() + q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t limit=1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
